// File: rtl/rx_fifo_if.sv
// MAC receive AXI-stream side and AHIR write-pipe side of the rx bridge.
// slave is the bridge itself; master is whatever drives the MAC beats and consumes the pipe.
interface rx_fifo_if #(parameter int N = 32) ();
   localparam int S = N / 8;
   localparam int D = N + S + 1;

   logic [N-1:0] rx_axis_tdata;
   logic [S-1:0] rx_axis_tkeep;
   logic         rx_axis_tvalid;
   logic         rx_axis_tlast;
   logic         rx_axis_tuser;
   logic         rx_axis_tready;
   logic [D-1:0] write_pipe_data;
   logic         write_pipe_req;
   logic         write_pipe_ack;

   modport slave (
      input  rx_axis_tdata,
      input  rx_axis_tkeep,
      input  rx_axis_tvalid,
      input  rx_axis_tlast,
      input  rx_axis_tuser,
      output rx_axis_tready,
      output write_pipe_data,
      output write_pipe_req,
      input  write_pipe_ack
   );

   modport master (
      output rx_axis_tdata,
      output rx_axis_tkeep,
      output rx_axis_tvalid,
      output rx_axis_tlast,
      output rx_axis_tuser,
      input  rx_axis_tready,
      input  write_pipe_data,
      input  write_pipe_req,
      output write_pipe_ack
   );
endinterface

// File: rtl/rx_fifo.sv
// AXI-stream rx beats -> DEPTH-word FIFO -> AHIR req/ack pipe; head word visible the cycle after the push.
// tready/req are registered from the next level; no push accepted while full, even with a same-cycle pop.
module rx_fifo #(
   parameter int N = 32,
   parameter int A = 3
) (
   input  logic         clk,
   input  logic         reset,
   rx_fifo_if.slave     bus,
   output logic [15:0]  frame_count,
   output logic [15:0]  bad_frame_count,
   output logic [A:0]   fifo_level
);
   localparam int S     = N / 8;
   localparam int D     = N + S + 1;
   localparam int DEPTH = 1 << A;
   localparam logic [A:0] LVL_ONE  = {{A{1'b0}}, 1'b1};
   localparam logic [A:0] LVL_FULL = {1'b1, {A{1'b0}}};

   logic [D-1:0] mem [DEPTH];
   logic [A-1:0] wr_ptr;
   logic [A-1:0] rd_ptr;
   logic [A:0]   level;
   logic [A:0]   next_level;
   logic         tready_q;
   logic         req_q;
   logic         push;
   logic         pop;
   logic         is_bad;
   logic [S-1:0] keep;
   logic [D-1:0] word;

   assign push   = bus.rx_axis_tvalid & tready_q;
   assign pop    = req_q & bus.write_pipe_ack;
   assign is_bad = bus.rx_axis_tlast & bus.rx_axis_tuser;
   // keep=0 on the last beat marks the whole frame as bad for downstream
   assign keep   = is_bad ? '0 : bus.rx_axis_tkeep;
   assign word   = {bus.rx_axis_tlast, bus.rx_axis_tdata, keep};

   always_comb begin
      next_level = level;
      if (push && !pop)
         next_level = level + LVL_ONE;
      else if (pop && !push)
         next_level = level - LVL_ONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         tready_q        <= 1'b0;
         req_q           <= 1'b0;
         frame_count     <= '0;
         bad_frame_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level    <= next_level;
         tready_q <= (next_level != LVL_FULL);
         req_q    <= (next_level != '0);
         if (push && bus.rx_axis_tlast && frame_count != 16'hFFFF)
            frame_count <= frame_count + 16'd1;
         if (push && is_bad && bad_frame_count != 16'hFFFF)
            bad_frame_count <= bad_frame_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= word;
   end

   assign bus.rx_axis_tready  = tready_q;
   assign bus.write_pipe_req  = req_q;
   assign bus.write_pipe_data = req_q ? mem[rd_ptr] : '0;
   assign fifo_level          = level;
endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: per-cycle vector table plus hand sequences, with a queue scoreboard on the pipe side.
module tb_rx_fifo;
   localparam int N = 32;
   localparam int A = 3;
   localparam int D = 37;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] frame_count;
   logic [15:0] bad_frame_count;
   logic [A:0]  fifo_level;

   always #5 clk = ~clk;

   rx_fifo_if #(.N(N)) bus ();

   rx_fifo #(.N(N), .A(A)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .frame_count     (frame_count),
      .bad_frame_count (bad_frame_count),
      .fifo_level      (fifo_level)
   );

   typedef struct {
      logic        vld;
      logic [31:0] dat;
      logic [3:0]  keep;
      logic        last;
      logic        user;
      logic        ack;
      logic        exp_req;
      logic [3:0]  exp_lvl;
      logic [D-1:0] exp_word;
      logic [15:0] exp_fr;
      logic [15:0] exp_bad;
   } vec_t;

   vec_t         vecs [12];
   int           n_checks = 0;
   int           n_pass = 0;
   int           pops = 0;
   logic [D-1:0] sb [$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(logic vld, logic [31:0] dat, logic [3:0] keep, logic last,
                               logic user, logic ack, logic exp_req, logic [3:0] exp_lvl,
                               logic [D-1:0] exp_word, logic [15:0] exp_fr, logic [15:0] exp_bad);
      vec_t v;
      v.vld = vld; v.dat = dat; v.keep = keep; v.last = last; v.user = user; v.ack = ack;
      v.exp_req = exp_req; v.exp_lvl = exp_lvl; v.exp_word = exp_word;
      v.exp_fr = exp_fr; v.exp_bad = exp_bad;
      return v;
   endfunction

   // Scoreboard: expected words enter on accepted beats, leave on pipe handshakes
   always @(negedge clk) begin
      if (reset) begin
         if (bus.write_pipe_req && bus.write_pipe_ack) begin
            pops++;
            if (sb.size() == 0)
               check("sb_unexpected_word", 64'(bus.write_pipe_data), 64'hDEAD);
            else
               check("sb_pipe_word", 64'(bus.write_pipe_data), 64'(sb.pop_front()));
         end
         if (bus.rx_axis_tvalid && bus.rx_axis_tready)
            sb.push_back({bus.rx_axis_tlast, bus.rx_axis_tdata,
                          (bus.rx_axis_tlast && bus.rx_axis_tuser) ? 4'h0 : bus.rx_axis_tkeep});
      end
   end

   task automatic send(logic [31:0] d, logic [3:0] k, logic l, logic u);
      logic ok = 1'b0;
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tdata  = d;
      bus.rx_axis_tkeep  = k;
      bus.rx_axis_tlast  = l;
      bus.rx_axis_tuser  = u;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         ok = bus.rx_axis_tready;
         @(posedge clk);
         #1;
      end
      bus.rx_axis_tvalid = 1'b0;
      if (!ok)
         check("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      bus.write_pipe_ack = 1'b1;
      for (int t = 0; t < 40 && fifo_level != 0; t++) begin
         @(posedge clk);
         #1;
      end
      bus.write_pipe_ack = 1'b0;
      check("drain_level", 64'(fifo_level), 64'd0);
      check("drain_req", 64'(bus.write_pipe_req), 64'd0);
   endtask

   task automatic pushpop(int lvl, logic [31:0] base);
      bus.write_pipe_ack = 1'b0;
      for (int i = 0; i < lvl; i++)
         send(base + 32'(i), 4'hF, 1'b0, 1'b0);
      check("pp_fill_level", 64'(fifo_level), 64'(lvl));
      bus.write_pipe_ack = 1'b1;
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tkeep  = 4'hF;
      bus.rx_axis_tlast  = 1'b0;
      bus.rx_axis_tuser  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         bus.rx_axis_tdata = base + 32'(lvl + c);
         @(posedge clk);
         #1;
         check("pp_level_const", 64'(fifo_level), 64'(lvl));
      end
      bus.rx_axis_tvalid = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int  acc;
      logic took;

      bus.rx_axis_tvalid = 1'b0;
      bus.rx_axis_tdata  = '0;
      bus.rx_axis_tkeep  = '0;
      bus.rx_axis_tlast  = 1'b0;
      bus.rx_axis_tuser  = 1'b0;
      bus.write_pipe_ack = 1'b0;

      vecs[0]  = mk(1, 32'hDEADBEEF, 4'hF, 1, 0, 1, 1, 4'd1, {1'b1, 32'hDEADBEEF, 4'hF}, 16'd1, 16'd0);
      vecs[1]  = mk(0, 32'h0,        4'h0, 0, 0, 1, 0, 4'd0, '0,                         16'd1, 16'd0);
      vecs[2]  = mk(1, 32'h11111111, 4'hF, 0, 0, 1, 1, 4'd1, {1'b0, 32'h11111111, 4'hF}, 16'd1, 16'd0);
      vecs[3]  = mk(1, 32'h22222222, 4'hF, 0, 0, 1, 1, 4'd1, {1'b0, 32'h22222222, 4'hF}, 16'd1, 16'd0);
      vecs[4]  = mk(1, 32'h33333333, 4'h3, 1, 0, 1, 1, 4'd1, {1'b1, 32'h33333333, 4'h3}, 16'd2, 16'd0);
      vecs[5]  = mk(0, 32'h0,        4'h0, 0, 0, 1, 0, 4'd0, '0,                         16'd2, 16'd0);
      vecs[6]  = mk(1, 32'hAAAA0001, 4'hF, 0, 0, 1, 1, 4'd1, {1'b0, 32'hAAAA0001, 4'hF}, 16'd2, 16'd0);
      vecs[7]  = mk(1, 32'hAAAA0002, 4'hF, 1, 1, 1, 1, 4'd1, {1'b1, 32'hAAAA0002, 4'h0}, 16'd3, 16'd1);
      vecs[8]  = mk(0, 32'h0,        4'h0, 0, 0, 1, 0, 4'd0, '0,                         16'd3, 16'd1);
      vecs[9]  = mk(1, 32'hBBBB0001, 4'hF, 0, 1, 1, 1, 4'd1, {1'b0, 32'hBBBB0001, 4'hF}, 16'd3, 16'd1);
      vecs[10] = mk(1, 32'hBBBB0002, 4'hF, 1, 0, 1, 1, 4'd1, {1'b1, 32'hBBBB0002, 4'hF}, 16'd4, 16'd1);
      vecs[11] = mk(0, 32'h0,        4'h0, 0, 0, 1, 0, 4'd0, '0,                         16'd4, 16'd1);

      // Reset state, then tready rises at the first edge after release
      #12;
      check("rst_tready", 64'(bus.rx_axis_tready), 64'd0);
      check("rst_req", 64'(bus.write_pipe_req), 64'd0);
      check("rst_data", 64'(bus.write_pipe_data), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_frames", 64'(frame_count), 64'd0);
      check("rst_bad", 64'(bad_frame_count), 64'd0);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("tready_after_release", 64'(bus.rx_axis_tready), 64'd1);

      for (int i = 0; i < 12; i++) begin
         bus.rx_axis_tvalid = vecs[i].vld;
         bus.rx_axis_tdata  = vecs[i].dat;
         bus.rx_axis_tkeep  = vecs[i].keep;
         bus.rx_axis_tlast  = vecs[i].last;
         bus.rx_axis_tuser  = vecs[i].user;
         bus.write_pipe_ack = vecs[i].ack;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_req", i), 64'(bus.write_pipe_req), 64'(vecs[i].exp_req));
         check($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_lvl));
         check($sformatf("vec%0d_tready", i), 64'(bus.rx_axis_tready), 64'd1);
         check($sformatf("vec%0d_data", i), 64'(bus.write_pipe_data), 64'(vecs[i].exp_word));
         check($sformatf("vec%0d_frames", i), 64'(frame_count), 64'(vecs[i].exp_fr));
         check($sformatf("vec%0d_bad", i), 64'(bad_frame_count), 64'(vecs[i].exp_bad));
      end
      bus.rx_axis_tvalid = 1'b0;
      bus.write_pipe_ack = 1'b0;

      // Backpressure: 10 attempted beats with the pipe stalled
      acc = 0;
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tkeep  = 4'hF;
      bus.rx_axis_tlast  = 1'b0;
      bus.rx_axis_tuser  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.rx_axis_tdata = 32'h100 + 32'(acc);
         @(negedge clk);
         took = bus.rx_axis_tready;
         @(posedge clk);
         #1;
         if (took) begin
            acc++;
            if (acc == 8)
               check("bp_tready_drop", 64'(bus.rx_axis_tready), 64'd0);
         end
      end
      check("bp_accepted", 64'(acc), 64'd8);
      check("bp_level_full", 64'(fifo_level), 64'd8);
      check("bp_tready_full", 64'(bus.rx_axis_tready), 64'd0);
      bus.rx_axis_tdata  = 32'h108;
      bus.write_pipe_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.write_pipe_ack = 1'b0;
      check("bp_level_after_pop", 64'(fifo_level), 64'd7);
      check("bp_tready_reassert", 64'(bus.rx_axis_tready), 64'd1);
      @(posedge clk);
      #1;
      bus.rx_axis_tvalid = 1'b0;
      check("bp_ninth_level", 64'(fifo_level), 64'd8);
      check("bp_ninth_tready", 64'(bus.rx_axis_tready), 64'd0);
      drain();

      pushpop(1, 32'h2000);
      pushpop(7, 32'h3000);

      // Reset in the middle of a frame with two words queued
      send(32'h4001, 4'hF, 1'b0, 1'b0);
      send(32'h4002, 4'hF, 1'b0, 1'b0);
      check("mid_level", 64'(fifo_level), 64'd2);
      check("mid_frames_nonzero", 64'(frame_count != 0), 64'd1);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_req", 64'(bus.write_pipe_req), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      check("mid_rst_frames", 64'(frame_count), 64'd0);
      check("mid_rst_bad", 64'(bad_frame_count), 64'd0);
      check("mid_rst_data", 64'(bus.write_pipe_data), 64'd0);
      sb.delete();
      pops = 0;
      @(negedge clk);
      reset = 1'b1;
      bus.write_pipe_ack = 1'b1;
      send(32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
      for (int t = 0; t < 5; t++) begin
         @(posedge clk);
         #1;
      end
      bus.write_pipe_ack = 1'b0;
      check("post_rst_pops", 64'(pops), 64'd1);
      check("post_rst_level", 64'(fifo_level), 64'd0);
      check("post_rst_frames", 64'(frame_count), 64'd1);
      check("sb_empty_at_end", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
